// File: rtl/ps2_receptor.sv
// ps2_receptor: PS/2 keyboard frame receiver.
//
// Conditions the raw PS/2 clock (2-FF synchroniser plus a run-length glitch
// filter), detects its falling edges and shifts in 11-bit frames: start (0),
// eight data bits LSB first, odd parity and stop (1). A good frame raises
// rx_done_tick for one cycle with the byte on dout. A frame with a bad parity
// or stop bit, or one that stalls mid-way, raises err_tick instead.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   ps2c, ps2d   raw PS/2 clock and data lines (asynchronous)
//   rx_en        gates the start of a new frame only
//   rx_done_tick one-cycle strobe, valid byte on dout
//   dout         last valid byte, held until the next valid frame
//   err_tick     one-cycle strobe, frame discarded
module ps2_receptor #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       err_tick
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

    // Line conditioning
    logic                  c_meta_q, c_sync_q;
    logic                  d_meta_q, d_sync_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  f_ps2c_q, f_ps2c_d;
    logic                  f_ps2c_prev_q;
    logic                  fall_tick;

    // Frame receiver
    state_e                state_q, state_d;
    logic [3:0]            n_q, n_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;
    logic [9:0]            b_reg_q, b_reg_d;
    logic [7:0]            dout_q, dout_d;
    logic                  frame_ok;

    // Filtered clock only moves once FILTER_LEN identical samples agree, so
    // shorter glitches leave it where it was.
    always_comb begin
        filt_d   = {filt_q[FILTER_LEN-2:0], c_sync_q};
        f_ps2c_d = f_ps2c_q;
        if (&filt_q) begin
            f_ps2c_d = 1'b1;
        end else if (~|filt_q) begin
            f_ps2c_d = 1'b0;
        end
    end

    assign fall_tick = f_ps2c_prev_q & ~f_ps2c_q;

    // After ten shifts b_reg_q holds {stop, parity, d7..d0}.
    assign frame_ok = b_reg_q[9] & (^b_reg_q[8:0]);

    // State register (all flops)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_meta_q      <= 1'b1;
            c_sync_q      <= 1'b1;
            d_meta_q      <= 1'b1;
            d_sync_q      <= 1'b1;
            filt_q        <= '1;
            f_ps2c_q      <= 1'b1;
            f_ps2c_prev_q <= 1'b1;
            state_q       <= StIdle;
            n_q           <= 4'd0;
            tmo_q         <= '0;
            b_reg_q       <= 10'd0;
            dout_q        <= 8'h00;
        end else begin
            c_meta_q      <= ps2c;
            c_sync_q      <= c_meta_q;
            d_meta_q      <= ps2d;
            d_sync_q      <= d_meta_q;
            filt_q        <= filt_d;
            f_ps2c_q      <= f_ps2c_d;
            f_ps2c_prev_q <= f_ps2c_q;
            state_q       <= state_d;
            n_q           <= n_d;
            tmo_q         <= tmo_d;
            b_reg_q       <= b_reg_d;
            dout_q        <= dout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        tmo_d   = tmo_q;
        b_reg_d = b_reg_q;
        dout_d  = dout_q;
        unique case (state_q)
            StIdle: begin
                // A start bit that reads 1 is noise; stay put silently.
                if (fall_tick && rx_en && !d_sync_q) begin
                    state_d = StShift;
                    n_d     = 4'd0;
                    tmo_d   = '0;
                end
            end
            StShift: begin
                if (fall_tick) begin
                    b_reg_d = {d_sync_q, b_reg_q[9:1]};
                    n_d     = n_q + 4'd1;
                    tmo_d   = '0;
                    if (n_q == 4'd9) begin
                        state_d = StCheck;
                    end
                end else if (tmo_q == TmoLast) begin
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StCheck: begin
                state_d = StIdle;
                if (frame_ok) begin
                    dout_d = b_reg_q[7:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs. dout bypasses dout_q during CHECK so the new byte appears on
    // the same edge that raises rx_done_tick.
    always_comb begin
        rx_done_tick = 1'b0;
        err_tick     = 1'b0;
        dout         = dout_q;
        unique case (state_q)
            StShift: begin
                err_tick = !fall_tick && (tmo_q == TmoLast);
            end
            StCheck: begin
                rx_done_tick = frame_ok;
                err_tick     = !frame_ok;
                if (frame_ok) begin
                    dout = b_reg_q[7:0];
                end
            end
            default: ;
        endcase
    end

endmodule
